// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: N-bit dividend by M-bit divisor, one quotient
// bit per clock, start/done handshake with registered results.
module seq_divider #(
  parameter int N = 6,
  parameter int M = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_r;
  logic [1:0]    state_s;
  logic [N-1:0]  a_q;        // dividend shifts out the top, quotient bits shift in at the bottom
  logic [M-1:0]  b_q;
  logic [M:0]    r_q;
  logic [CW-1:0] cnt_r;
  logic          zero_r;
  logic [M:0]    t_s;
  logic [M:0]    r_next_s;
  logic          qbit_s;

  // One restoring step: trial subtract of the divisor from the shifted partial remainder.
  always_comb begin
    t_s      = {r_q[M-1:0], a_q[N-1]};
    r_next_s = t_s;
    qbit_s   = 1'b0;
    if (r_q[M] || (t_s >= {1'b0, b_q})) begin
      r_next_s = t_s - {1'b0, b_q};
      qbit_s   = 1'b1;
    end else begin
      r_next_s = t_s;
      qbit_s   = 1'b0;
    end
  end

  // Next-state logic; a zero divisor leaves RUN on its first cycle without iterating.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (zero_r || (cnt_r == CW'(1))) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      a_q         <= {N{1'b0}};
      b_q         <= {M{1'b0}};
      r_q         <= {(M+1){1'b0}};
      cnt_r       <= {CW{1'b0}};
      zero_r      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {N{1'b0}};
      remainder   <= {M{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != IDLE);
      done    <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_q    <= dividend;
            b_q    <= divisor;
            r_q    <= {(M+1){1'b0}};
            cnt_r  <= CW'(N);
            zero_r <= (divisor == {M{1'b0}});
          end
        end
        RUN: begin
          if (zero_r) begin
            quotient    <= {N{1'b1}};
            remainder   <= a_q[M-1:0];
            div_by_zero <= 1'b1;
          end else begin
            a_q   <= {a_q[N-2:0], qbit_s};
            r_q   <= r_next_s;
            cnt_r <= cnt_r - CW'(1);
            if (cnt_r == CW'(1)) begin
              quotient    <= {a_q[N-2:0], qbit_s};
              remainder   <= r_next_s[M-1:0];
              div_by_zero <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: latency, boundaries, divide by zero,
// ignored start, mid-operation reset and an exhaustive back-to-back sweep.
module tb_seq_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] dividend;
  logic [2:0] divisor;
  logic       busy;
  logic       done;
  logic [5:0] quotient;
  logic [2:0] remainder;
  logic       div_by_zero;

  int vectors;
  int miscompares;

  seq_divider #(.N(6), .M(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one division and watch 20 cycles from the acceptance edge onward.
  task automatic run_op(input logic [5:0] dd, input logic [2:0] dv,
                        output int nb, output int nd, output int dc,
                        output logic [31:0] q, output logic [31:0] r, output logic [31:0] z);
    nb = 0; nd = 0; dc = -1; q = 0; r = 0; z = 0;
    @(negedge clk);
    dividend = dd; divisor = dv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = ~dd; divisor = ~dv;
    for (int i = 0; i < 20; i++) begin
      if (busy) nb++;
      if (done) begin
        nd++; dc = i; q = 32'(quotient); r = 32'(remainder); z = 32'(div_by_zero);
      end
      @(negedge clk);
    end
  endtask

  int nb, nd, dc;
  logic [31:0] q, r, z;
  int k, last_done, ddi, dvi;

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; start = 1'b0; dividend = 6'd0; divisor = 3'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quot", 32'(quotient), 32'd0);
    check("rst_rem", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;

    // 45/6: busy for 7 cycles, done in the 7th
    run_op(6'd45, 3'd6, nb, nd, dc, q, r, z);
    check("45_6_busy_cycles", nb, 32'd7);
    check("45_6_done_count", nd, 32'd1);
    check("45_6_done_cycle", dc, 32'd6);
    check("45_6_quot", q, 32'd7);
    check("45_6_rem", r, 32'd3);
    check("45_6_dbz", z, 32'd0);

    run_op(6'd63, 3'd7, nb, nd, dc, q, r, z);
    check("63_7_quot", q, 32'd9);
    check("63_7_rem", r, 32'd0);
    check("63_7_done_cycle", dc, 32'd6);
    run_op(6'd5, 3'd7, nb, nd, dc, q, r, z);
    check("5_7_quot", q, 32'd0);
    check("5_7_rem", r, 32'd5);
    run_op(6'd63, 3'd1, nb, nd, dc, q, r, z);
    check("63_1_quot", q, 32'd63);
    check("63_1_rem", r, 32'd0);
    check("63_1_dbz", z, 32'd0);
    run_op(6'd0, 3'd3, nb, nd, dc, q, r, z);
    check("0_3_quot", q, 32'd0);
    check("0_3_rem", r, 32'd0);

    // divide by zero: done in the second busy cycle
    run_op(6'd20, 3'd0, nb, nd, dc, q, r, z);
    check("20_0_done_count", nd, 32'd1);
    check("20_0_done_cycle", dc, 32'd1);
    check("20_0_busy_cycles", nb, 32'd2);
    check("20_0_quot", q, 32'd63);
    check("20_0_rem", r, 32'd4);
    check("20_0_dbz", z, 32'd1);

    // start while busy is ignored
    @(negedge clk);
    dividend = 6'd45; divisor = 3'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 6'd10; divisor = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0; q = 0; r = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        nd++; q = 32'(quotient); r = 32'(remainder);
      end
      @(negedge clk);
    end
    check("busy_start_done_count", nd, 32'd1);
    check("busy_start_quot", q, 32'd7);
    check("busy_start_rem", r, 32'd3);
    check("busy_start_hold_quot", 32'(quotient), 32'd7);
    check("busy_start_hold_rem", 32'(remainder), 32'd3);
    check("busy_start_idle", 32'(busy), 32'd0);

    // reset during the 3rd RUN cycle
    @(negedge clk);
    dividend = 6'd45; divisor = 3'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_quot", 32'(quotient), 32'd0);
    check("midrst_rem", 32'(remainder), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) nd++;
      @(negedge clk);
    end
    check("midrst_no_done", nd, 32'd0);
    run_op(6'd9, 3'd2, nb, nd, dc, q, r, z);
    check("9_2_quot", q, 32'd4);
    check("9_2_rem", r, 32'd1);
    check("9_2_done_cycle", dc, 32'd6);

    // exhaustive, start held high; operands advance on each done
    k = 0; last_done = -1;
    dividend = 6'd0; divisor = 3'd0; start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 6000 && k < 512; c++) begin
      if (done) begin
        ddi = k >> 3; dvi = k & 7;
        if (dvi == 0) begin
          check("exh_dz_quot", 32'(quotient), 32'd63);
          check("exh_dz_rem", 32'(remainder), 32'(ddi % 8));
          check("exh_dz_flag", 32'(div_by_zero), 32'd1);
        end else begin
          check("exh_identity", 32'(quotient) * 32'(dvi) + 32'(remainder), 32'(ddi));
          check("exh_rem_lt", 32'(remainder < 3'(dvi)), 32'd1);
          check("exh_flag", 32'(div_by_zero), 32'd0);
        end
        if (last_done >= 0) check("exh_spacing", c - last_done, (dvi == 0) ? 32'd3 : 32'd8);
        last_done = c;
        k++;
        dividend = 6'(k >> 3); divisor = 3'(k & 7);
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("exh_all_done", k, 32'd512);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
